// File: rtl/clcd_pkg.sv
// Shared types and constants for the CLCD-over-I2C path: FSM states,
// PCF8574 backpack bit positions, HD44780 slow-command codes.
package clcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        HOLD
    } state_t;

    localparam int BIT_RS = 0;
    localparam int BIT_RW = 1;
    localparam int BIT_E  = 2;
    localparam int BIT_BL = 3;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    function automatic logic [7:0] pcf_byte(input logic [3:0] nib, input logic bl,
                                            input logic e, input logic rw, input logic rs);
        logic [7:0] b;
        b         = {nib, 4'b0000};
        b[BIT_BL] = bl;
        b[BIT_E]  = e;
        b[BIT_RW] = rw;
        b[BIT_RS] = rs;
        return b;
    endfunction

    // Clear (0x01) and both home encodings (0x02/0x03) need the long settle time.
    function automatic logic is_long_cmd(input logic [7:0] data, input logic rs);
        return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
    endfunction

endpackage

// File: rtl/edge_detector_n.sv
// Single-register edge detector: one-cycle rise/fall pulses for a level input.
module edge_detector_n (
    input  logic clk,
    input  logic reset_p,
    input  logic cp,
    output logic p_edge,
    output logic n_edge
);

    logic cp_d;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) cp_d <= 1'b0;
        else         cp_d <= cp;
    end

    assign p_edge = cp & ~cp_d;
    assign n_edge = ~cp & cp_d;

endmodule

// File: rtl/clcd_i2c_nibble_tx.sv
// Splits one HD44780 command into four PCF8574 byte writes (4-bit mode, E strobe)
// and paces them to the I2C master. Optional watchdog: CLCD_I2C_TX_TIMEOUT_EN.
module clcd_i2c_nibble_tx
    import clcd_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR    = 7'h27,
    parameter int         HOLD_CYC      = 5000,
    parameter int         HOLD_LONG_CYC = 200000,
    parameter bit         BL_ON         = 1'b1
`ifdef CLCD_I2C_TX_TIMEOUT_EN
   ,parameter int         TIMEOUT_CYC   = 1_000_000
`endif
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [7:0] i_data,
    input  logic       i_RS,
    input  logic       i_RW,
    input  logic       i_valid,
    output logic       o_busy,
    output logic [6:0] o_i2c_addr,
    output logic [7:0] o_i2c_data,
    output logic       o_i2c_valid,
    input  logic       i_i2c_busy,
    output logic       o_error
);

    localparam int HOLD_MAX = (HOLD_CYC > HOLD_LONG_CYC) ? HOLD_CYC : HOLD_LONG_CYC;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    state_t            state, state_n;
    logic [1:0]        idx, idx_n;
    logic [7:0]        cmd_data, cmd_data_n;
    logic              cmd_rs, cmd_rs_n;
    logic              cmd_rw, cmd_rw_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic              busy_r, busy_n;
    logic              valid_r, valid_n;
    logic [7:0]        data_r, data_n;
    logic              busy_rise, busy_fall;
    logic [3:0]        cur_nib;

    edge_detector_n u_busy_edge (
        .clk     (clk),
        .reset_p (reset_p),
        .cp      (i_i2c_busy),
        .p_edge  (busy_rise),
        .n_edge  (busy_fall)
    );

    // idx[1] picks the nibble, idx[0] clears E on the second write of each pair.
    assign cur_nib = idx[1] ? cmd_data[3:0] : cmd_data[7:4];

`ifdef CLCD_I2C_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt, wd_n;
    logic            err_r, err_n;
`endif

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cmd_data_n = cmd_data;
        cmd_rs_n   = cmd_rs;
        cmd_rw_n   = cmd_rw;
        hold_cnt_n = hold_cnt;
        busy_n     = busy_r;
        valid_n    = valid_r;
        data_n     = data_r;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    cmd_data_n = i_data;
                    cmd_rs_n   = i_RS;
                    cmd_rw_n   = i_RW;
                    busy_n     = 1'b1;
                    idx_n      = 2'd0;
                    state_n    = SEND;
                end
            end
            SEND: begin
                data_n  = pcf_byte(cur_nib, BL_ON, ~idx[0], cmd_rw, cmd_rs);
                valid_n = 1'b1;
                state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (busy_rise) begin
                    valid_n = 1'b0;
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (busy_fall) begin
                    if (idx != 2'd3) begin
                        idx_n   = idx + 2'd1;
                        state_n = SEND;
                    end else begin
                        hold_cnt_n = is_long_cmd(cmd_data, cmd_rs) ? HOLD_W'(HOLD_LONG_CYC)
                                                                   : HOLD_W'(HOLD_CYC);
                        state_n    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt <= HOLD_W'(1)) begin
                    hold_cnt_n = '0;
                    busy_n     = 1'b0;
                    state_n    = IDLE;
                end else begin
                    hold_cnt_n = hold_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef CLCD_I2C_TX_TIMEOUT_EN
        err_n = err_r;
        wd_n  = '0;
        if ((state == WAIT_ACK || state == WAIT_DONE) && state_n == state)
            wd_n = wd_cnt + 1'b1;
        // Expiry abandons the rest of the command; the flag stays until reset.
        if ((state == WAIT_ACK || state == WAIT_DONE) && wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
            err_n   = 1'b1;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            state_n = IDLE;
            wd_n    = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state    <= IDLE;
            idx      <= 2'd0;
            cmd_data <= 8'h00;
            cmd_rs   <= 1'b0;
            cmd_rw   <= 1'b0;
            hold_cnt <= '0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            data_r   <= 8'h00;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cmd_data <= cmd_data_n;
            cmd_rs   <= cmd_rs_n;
            cmd_rw   <= cmd_rw_n;
            hold_cnt <= hold_cnt_n;
            busy_r   <= busy_n;
            valid_r  <= valid_n;
            data_r   <= data_n;
        end
    end

`ifdef CLCD_I2C_TX_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            wd_cnt <= '0;
            err_r  <= 1'b0;
        end else begin
            wd_cnt <= wd_n;
            err_r  <= err_n;
        end
    end

    assign o_error = err_r;
`else
    assign o_error = 1'b0;
`endif

    assign o_busy      = busy_r;
    assign o_i2c_valid = valid_r;
    assign o_i2c_data  = data_r;
    assign o_i2c_addr  = SLAVE_ADDR;

endmodule

// File: tb/tb_clcd_i2c_nibble_tx.sv
// Self-checking bench for clcd_i2c_nibble_tx: a scripted I2C-master model serves
// the byte handshake; expected bytes and hold lengths come from a plain-arithmetic model.
module tb_clcd_i2c_nibble_tx;

    localparam int HOLD_S = 50;
    localparam int HOLD_L = 300;
    localparam int BL     = 1;
    localparam int TMO    = 100;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic [7:0] i_data = 8'h00;
    logic       i_RS = 1'b0;
    logic       i_RW = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_busy;
    logic [6:0] o_i2c_addr;
    logic [7:0] o_i2c_data;
    logic       o_i2c_valid;
    logic       i_i2c_busy = 1'b0;
    logic       o_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clcd_i2c_nibble_tx #(
        .SLAVE_ADDR    (7'h27),
        .HOLD_CYC      (HOLD_S),
        .HOLD_LONG_CYC (HOLD_L),
        .BL_ON         (1'b1)
`ifdef CLCD_I2C_TX_TIMEOUT_EN
       ,.TIMEOUT_CYC   (TMO)
`endif
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .i_data      (i_data),
        .i_RS        (i_RS),
        .i_RW        (i_RW),
        .i_valid     (i_valid),
        .o_busy      (o_busy),
        .o_i2c_addr  (o_i2c_addr),
        .o_i2c_data  (o_i2c_data),
        .o_i2c_valid (o_i2c_valid),
        .i_i2c_busy  (i_i2c_busy),
        .o_error     (o_error)
    );

    // Reference model: byte = nibble*16 + BL*8 + E*4 + RW*2 + RS, order hi/E1, hi/E0, lo/E1, lo/E0.
    function automatic logic [31:0] model_bytes(input int d, input int rs, input int rw);
        int hi, lo;
        int b [4];
        hi = d / 16;
        lo = d % 16;
        b[0] = hi * 16 + BL * 8 + 4 + rw * 2 + rs;
        b[1] = hi * 16 + BL * 8 + 0 + rw * 2 + rs;
        b[2] = lo * 16 + BL * 8 + 4 + rw * 2 + rs;
        b[3] = lo * 16 + BL * 8 + 0 + rw * 2 + rs;
        return {b[0][7:0], b[1][7:0], b[2][7:0], b[3][7:0]};
    endfunction

    function automatic int model_hold(input int d, input int rs);
        return (rs == 0 && d >= 1 && d <= 3) ? HOLD_L : HOLD_S;
    endfunction

    // Present a command; acc reports whether o_busy is up one cycle later.
    task automatic issue(input logic [7:0] d, input logic rs, input logic rw,
                         input bit keep, output bit acc);
        i_data  = d;
        i_RS    = rs;
        i_RW    = rw;
        i_valid = 1'b1;
        @(posedge clk); #1;
        acc = (o_busy === 1'b1);
        if (!keep) i_valid = 1'b0;
    endtask

    // I2C master model: serves four bytes, then measures the hold (edges after the
    // edge that samples the last busy fall, until o_busy reads low).
    task automatic serve(input int ack_delay, input int busy_len,
                         output logic [31:0] got, output int hold_seen,
                         output int stable_bad, output int drop_bad, output int tmo);
        int n;
        logic [7:0] cur;
        got = '0; stable_bad = 0; drop_bad = 0; tmo = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (o_i2c_valid !== 1'b1 && n < 100) begin
                @(posedge clk); #1; n++;
            end
            if (n >= 100) tmo++;
            cur = o_i2c_data;
            got = {got[23:0], cur};
            repeat (ack_delay) begin
                @(posedge clk); #1;
                if (o_i2c_valid !== 1'b1 || o_i2c_data !== cur) stable_bad++;
            end
            i_i2c_busy = 1'b1;
            @(posedge clk); #1;
            if (o_i2c_valid !== 1'b0) drop_bad++;
            repeat (busy_len) @(posedge clk);
            #1 i_i2c_busy = 1'b0;
        end
        @(posedge clk); #1;
        n = 0;
        while (o_busy === 1'b1 && n < HOLD_L + 100) begin
            @(posedge clk); #1; n++;
        end
        hold_seen = n;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({o_busy, o_i2c_valid, o_i2c_data, o_error} !== 11'd0) begin
            errors++;
            $display("FAIL reset_in: outputs got %b/%b/%h/%b want 0", o_busy, o_i2c_valid, o_i2c_data, o_error);
        end
        reset_p = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({o_busy, o_i2c_valid, o_i2c_data, o_error} !== 11'd0) begin
            errors++;
            $display("FAIL reset_out: outputs got %b/%b/%h/%b want 0", o_busy, o_i2c_valid, o_i2c_data, o_error);
        end
        checks++;
        if (o_i2c_addr !== 7'h27) begin
            errors++;
            $display("FAIL addr: got %h want 27", o_i2c_addr);
        end
    endtask

    task automatic run_one(input string name, input logic [7:0] d, input logic rs, input logic rw,
                           input int ack_delay, input int busy_len);
        bit acc;
        logic [31:0] got;
        int hold, sb, db, tmo;
        issue(d, rs, rw, 1'b0, acc);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: busy got %b want 1", name, o_busy);
        end
        serve(ack_delay, busy_len, got, hold, sb, db, tmo);
        checks++;
        if (got !== model_bytes(int'(d), int'(rs), int'(rw)) || tmo != 0) begin
            errors++;
            $display("FAIL %s bytes: got %h want %h (tmo %0d)", name, got, model_bytes(int'(d), int'(rs), int'(rw)), tmo);
        end
        checks++;
        if (hold != model_hold(int'(d), int'(rs))) begin
            errors++;
            $display("FAIL %s hold: got %0d want %0d", name, hold, model_hold(int'(d), int'(rs)));
        end
        checks++;
        if (sb != 0 || db != 0) begin
            errors++;
            $display("FAIL %s handshake: unstable %0d late_drop %0d want 0/0", name, sb, db);
        end
    endtask

    task automatic test_basic();
        run_one("cmd28", 8'h28, 1'b0, 1'b0, 0, 20);
        run_one("data41", 8'h41, 1'b1, 1'b0, 0, 20);
    endtask

    task automatic test_ack_delay();
        run_one("ack37", 8'hC3, 1'b1, 1'b1, 37, 8);
    endtask

    task automatic test_long_hold_pending();
        bit acc;
        logic [31:0] got;
        int hold, sb, db, tmo;
        issue(8'h01, 1'b0, 1'b0, 1'b1, acc);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL clear accept: busy got %b want 1", o_busy);
        end
        // Keep requesting with different contents while busy; the latched clear must be unaffected.
        i_data = 8'h5A;
        i_RS   = 1'b1;
        serve(0, 12, got, hold, sb, db, tmo);
        checks++;
        if (got !== model_bytes(1, 0, 0) || tmo != 0) begin
            errors++;
            $display("FAIL clear bytes: got %h want %h", got, model_bytes(1, 0, 0));
        end
        checks++;
        if (hold != model_hold(1, 0)) begin
            errors++;
            $display("FAIL clear hold: got %0d want %0d", hold, model_hold(1, 0));
        end
        @(posedge clk); #1;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL pending accept: busy got %b want 1", o_busy);
        end
        i_valid = 1'b0;
        serve(2, 5, got, hold, sb, db, tmo);
        checks++;
        if (got !== model_bytes(8'h5A, 1, 0) || hold != model_hold(8'h5A, 1)) begin
            errors++;
            $display("FAIL pending cmd: got %h/%0d want %h/%0d", got, hold, model_bytes(8'h5A, 1, 0), model_hold(8'h5A, 1));
        end
        run_one("home03", 8'h03, 1'b0, 1'b0, 1, 3);
        run_one("data02", 8'h02, 1'b1, 1'b0, 1, 3);
    endtask

    task automatic test_reset_mid();
        bit acc;
        int n;
        logic [31:0] exp;
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        exp = model_bytes(int'(d), 0, 1);
        issue(d, 1'b0, 1'b1, 1'b0, acc);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (o_i2c_valid !== 1'b1 && n < 100) begin
                @(posedge clk); #1; n++;
            end
            i_i2c_busy = 1'b1;
            repeat (5) @(posedge clk);
            #1 i_i2c_busy = 1'b0;
        end
        n = 0;
        while (o_i2c_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (o_i2c_data !== exp[15:8]) begin
            errors++;
            $display("FAIL mid idx2 byte: got %h want %h", o_i2c_data, exp[15:8]);
        end
        #2 reset_p = 1'b1;
        #1;
        checks++;
        if ({o_busy, o_i2c_valid, o_i2c_data, o_error} !== 11'd0) begin
            errors++;
            $display("FAIL mid reset: outputs got %b/%b/%h/%b want 0", o_busy, o_i2c_valid, o_i2c_data, o_error);
        end
        @(posedge clk); #1 reset_p = 1'b0;
        @(posedge clk); #1;
        run_one("after_rst", 8'h9E, 1'b1, 1'b0, 0, 4);
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic rs, rw;
        for (int i = 0; i < 8; i++) begin
            d  = 8'($urandom_range(0, 255));
            if (i == 0) d = 8'($urandom_range(1, 3));
            rs = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            if (i == 0) rs = 1'b0;
            run_one("rand", d, rs, rw, $urandom_range(0, 12), $urandom_range(1, 30));
        end
    endtask

`ifdef CLCD_I2C_TX_TIMEOUT_EN
    task automatic test_timeout();
        bit acc;
        int n;
        issue(8'h33, 1'b1, 1'b0, 1'b0, acc);
        n = 0;
        while (o_i2c_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        n = 0;
        while (o_error !== 1'b1 && n < 3 * TMO) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n != TMO) begin
            errors++;
            $display("FAIL timeout delay: got %0d want %0d", n, TMO);
        end
        checks++;
        if ({o_error, o_busy, o_i2c_valid} !== 3'b100) begin
            errors++;
            $display("FAIL timeout outs: err/busy/valid got %b%b%b want 100", o_error, o_busy, o_i2c_valid);
        end
        repeat (10) @(posedge clk); #1;
        checks++;
        if (o_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout sticky: got %b want 1", o_error);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_ack_delay();
        test_long_hold_pending();
        test_reset_mid();
        test_random();
`ifdef CLCD_I2C_TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
